// File: rtl/framebuffer_mem_ctrl.sv
// Framebuffer memory controller: byte reads served from 16-bit RGB565 RAM words through a
// one-word cache, plus a small write FIFO that drains into the RAM whenever reads are idle.
module framebuffer_mem_ctrl #(
  parameter int ADDR_W        = 17,
  parameter int DEPTH         = 76800,
  parameter int WR_FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_req,
  input  logic [31:0]       mem_addr,
  output logic              mem_ready,
  output logic [7:0]        mem_out,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [15:0]       ram_wdata,
  input  logic [15:0]       ram_rdata,
  output logic              oob_err,
  output logic              req_err
);
  localparam int IDX_W = (WR_FIFO_DEPTH > 1) ? $clog2(WR_FIFO_DEPTH) : 1;
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(WR_FIFO_DEPTH);
  localparam logic [31:0]      DEPTH_U  = 32'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2
  } state_t;

  state_t             state_r;
  logic [15:0]        cache_word_r;
  logic [ADDR_W-1:0]  cache_tag_r;
  logic               cache_valid_r;
  logic               byte_sel_r;
  logic [ADDR_W-1:0]  fifo_addr_r [WR_FIFO_DEPTH];
  logic [15:0]        fifo_data_r [WR_FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic               wr_ready_r;
  logic               mem_ready_r;
  logic [7:0]         mem_out_r;
  logic [ADDR_W-1:0]  ram_addr_r;
  logic               ram_we_r;
  logic [15:0]        ram_wdata_r;
  logic               oob_err_r;
  logic               req_err_r;

  logic [ADDR_W-1:0]  rd_word_s;
  logic               rd_oob_s;
  logic               rd_hit_s;
  logic               fifo_empty_s;
  logic               push_s;
  logic               pop_s;
  logic [ADDR_W-1:0]  head_addr_s;
  logic [15:0]        head_data_s;
  logic               head_oob_s;
  logic               head_hits_cache_s;
  logic [PTR_W-1:0]   wr_ptr_nxt_s;
  logic [PTR_W-1:0]   rd_ptr_nxt_s;
  logic [PTR_W-1:0]   fill_nxt_s;
  logic               unused_addr_s;

  function automatic logic [7:0] pick_byte(input logic [15:0] word, input logic sel);
    pick_byte = sel ? word[7:0] : word[15:8];
  endfunction

  assign rd_word_s     = mem_addr[ADDR_W:1];
  assign unused_addr_s = ^mem_addr[31:ADDR_W+1];
  assign rd_oob_s      = (32'(rd_word_s) >= DEPTH_U);
  assign rd_hit_s      = cache_valid_r && (cache_tag_r == rd_word_s);

  assign fifo_empty_s  = (wr_ptr_r == rd_ptr_r);
  assign push_s        = wr_valid && wr_ready_r;
  // Reads always win: the FIFO drains only on idle cycles without a request.
  assign pop_s         = (state_r == IDLE) && !mem_req && !fifo_empty_s;
  assign head_addr_s   = fifo_addr_r[rd_ptr_r[IDX_W-1:0]];
  assign head_data_s   = fifo_data_r[rd_ptr_r[IDX_W-1:0]];
  assign head_oob_s    = (32'(head_addr_s) >= DEPTH_U);
  assign head_hits_cache_s = cache_valid_r && (cache_tag_r == head_addr_s);

  assign wr_ptr_nxt_s  = wr_ptr_r + {{(PTR_W-1){1'b0}}, push_s};
  assign rd_ptr_nxt_s  = rd_ptr_r + {{(PTR_W-1){1'b0}}, pop_s};
  assign fill_nxt_s    = wr_ptr_nxt_s - rd_ptr_nxt_s;

  assign mem_ready = mem_ready_r;
  assign mem_out   = mem_out_r;
  assign wr_ready  = wr_ready_r;
  assign ram_addr  = ram_addr_r;
  assign ram_we    = ram_we_r;
  assign ram_wdata = ram_wdata_r;
  assign oob_err   = oob_err_r;
  assign req_err   = req_err_r;

  // Read FSM, cache, write FIFO and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      cache_word_r  <= 16'd0;
      cache_tag_r   <= '0;
      cache_valid_r <= 1'b0;
      byte_sel_r    <= 1'b0;
      for (int i = 0; i < WR_FIFO_DEPTH; i++) begin
        fifo_addr_r[i] <= '0;
        fifo_data_r[i] <= 16'd0;
      end
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      wr_ready_r    <= 1'b0;
      mem_ready_r   <= 1'b0;
      mem_out_r     <= 8'd0;
      ram_addr_r    <= '0;
      ram_we_r      <= 1'b0;
      ram_wdata_r   <= 16'd0;
      oob_err_r     <= 1'b0;
      req_err_r     <= 1'b0;
    end else begin
      mem_ready_r <= 1'b0;
      ram_we_r    <= 1'b0;
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      wr_ready_r  <= (fill_nxt_s != FULL_CNT);
      if (push_s) begin
        fifo_addr_r[wr_ptr_r[IDX_W-1:0]] <= wr_addr;
        fifo_data_r[wr_ptr_r[IDX_W-1:0]] <= wr_data;
      end else begin
        fifo_addr_r <= fifo_addr_r;
      end
      case (state_r)
        IDLE: begin
          if (mem_req) begin
            if (rd_oob_s) begin
              mem_out_r   <= 8'd0;
              mem_ready_r <= 1'b1;
              oob_err_r   <= 1'b1;
            end else if (rd_hit_s) begin
              mem_out_r   <= pick_byte(cache_word_r, mem_addr[0]);
              mem_ready_r <= 1'b1;
            end else begin
              ram_addr_r <= rd_word_s;
              byte_sel_r <= mem_addr[0];
              state_r    <= RD_ADDR;
            end
          end else if (pop_s) begin
            if (head_oob_s) begin
              oob_err_r <= 1'b1;
            end else begin
              ram_we_r    <= 1'b1;
              ram_addr_r  <= head_addr_s;
              ram_wdata_r <= head_data_s;
              // Keep the cached word coherent with the RAM it mirrors.
              if (head_hits_cache_s) begin
                cache_word_r <= head_data_s;
              end else begin
                cache_word_r <= cache_word_r;
              end
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RD_ADDR: begin
          if (mem_req) begin
            req_err_r <= 1'b1;
          end else begin
            req_err_r <= req_err_r;
          end
          state_r <= RD_DATA;
        end
        RD_DATA: begin
          if (mem_req) begin
            req_err_r <= 1'b1;
          end else begin
            req_err_r <= req_err_r;
          end
          cache_word_r  <= ram_rdata;
          cache_tag_r   <= ram_addr_r;
          cache_valid_r <= 1'b1;
          mem_out_r     <= pick_byte(ram_rdata, byte_sel_r);
          mem_ready_r   <= 1'b1;
          state_r       <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_framebuffer_mem_ctrl.sv
// Scoreboard bench for framebuffer_mem_ctrl: stimulus pushes expected reads/writes into queues,
// a negedge monitor pops them as mem_ready / ram_we appear, and a behavioural RAM answers reads.
module tb_framebuffer_mem_ctrl;
  localparam int ADDR_W = 17;
  localparam int DEPTH  = 76800;
  localparam int RAM_N  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              mem_req;
  logic [31:0]       mem_addr;
  logic              mem_ready;
  logic [7:0]        mem_out;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [15:0]       ram_wdata;
  logic [15:0]       ram_rdata;
  logic              oob_err;
  logic              req_err;

  typedef struct { logic [7:0] data; int cyc; } rd_exp_t;
  typedef struct { logic [16:0] addr; logic [15:0] data; } wr_exp_t;

  rd_exp_t     rq[$];
  wr_exp_t     wq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] ram_arr [RAM_N];
  bit          ram_wr  [RAM_N];
  logic [15:0] ref_arr [RAM_N];
  bit          ref_wr  [RAM_N];
  bit          mc_valid;
  logic [16:0] mc_tag;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  framebuffer_mem_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WR_FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_out(mem_out), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .oob_err(oob_err), .req_err(req_err)
  );

  function automatic logic [15:0] init_word(input int a);
    logic [31:0] h;
    if (a == 5) return 16'hF800;
    h = a * 32'h9E37 + 32'h1234;
    return h[15:0];
  endfunction

  // Single-port synchronous RAM, read-first.
  always @(posedge clk) begin
    if (ram_we === 1'b1) begin
      ram_arr[ram_addr] <= ram_wdata;
      ram_wr[ram_addr]  <= 1'b1;
    end
    ram_rdata <= ram_wr[ram_addr] ? ram_arr[ram_addr] : init_word(int'(ram_addr));
  end

  function automatic logic [15:0] ref_word(input logic [16:0] w);
    return ref_wr[w] ? ref_arr[w] : init_word(int'(w));
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] got);
    checks++;
    errors++;
    $display("FAIL %s: got 0x%0h, expected no such event (cycle %0d)", name, got, cyc);
  endtask

  task automatic monitor();
    logic    prev_ready;
    logic    busy_prev;
    rd_exp_t re;
    wr_exp_t we;
    prev_ready = 1'b0;
    busy_prev  = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_ready === 1'b1) begin
        check("ready_gap", 32'(prev_ready), 32'd0);
        if (rq.size() == 0) begin
          fail("ready_unexpected", 32'(mem_out));
        end else begin
          re = rq.pop_front();
          check("rd_data", 32'(mem_out), 32'(re.data));
          check("rd_latency", 32'(cyc), 32'(re.cyc));
        end
      end
      prev_ready = (mem_ready === 1'b1);
      if (ram_we === 1'b1) begin
        check("wr_idle_slot", 32'(busy_prev), 32'd0);
        if (wq.size() == 0) begin
          fail("wr_unexpected", 32'(ram_addr));
        end else begin
          we = wq.pop_front();
          check("wr_addr", 32'(ram_addr), 32'(we.addr));
          check("wr_data", 32'(ram_wdata), 32'(we.data));
        end
      end
      busy_prev = (mem_req === 1'b1) || (rq.size() != 0);
    end
  endtask

  task automatic issue_read(input logic [31:0] a);
    logic [16:0] w;
    logic [15:0] d;
    rd_exp_t     e;
    int          lat;
    w = a[17:1];
    if (int'(w) >= DEPTH) begin
      d   = 16'h0000;
      lat = 1;
    end else begin
      d   = ref_word(w);
      lat = (mc_valid && mc_tag == w) ? 1 : 3;
      mc_valid = 1'b1;
      mc_tag   = w;
    end
    e.data = a[0] ? d[7:0] : d[15:8];
    e.cyc  = cyc + lat;
    rq.push_back(e);
    mem_req  = 1'b1;
    mem_addr = a;
    @(posedge clk); #1;
    mem_req = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input int post);
    issue_read(a);
    repeat (post) begin @(posedge clk); #1; end
  endtask

  task automatic do_write(input logic [16:0] a, input logic [15:0] d);
    wr_exp_t e;
    int      n;
    n = 0;
    while (wr_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    if (wr_ready !== 1'b1) begin
      fail("wr_ready_timeout", 32'(wr_ready));
      return;
    end
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    if (int'(a) < DEPTH) begin
      e.addr = a;
      e.data = d;
      wq.push_back(e);
      ref_arr[a] = d;
      ref_wr[a]  = 1'b1;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (wq.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    if (wq.size() != 0) fail("drain_timeout", 32'(wq.size()));
    @(posedge clk); #1;
  endtask

  initial begin
    mem_req  = 1'b0;
    mem_addr = 32'd0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = 16'd0;
    mc_valid = 1'b0;
    mc_tag   = '0;
    fork
      monitor();
      begin
        repeat (30000) @(posedge clk);
        fail("watchdog", 32'(cyc));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    check("rst_mem_out", 32'(mem_out), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    check("rst_oob_err", 32'(oob_err), 32'd0);
    check("rst_req_err", 32'(req_err), 32'd0);
    reset = 1'b1;
    #1 check("rel_wr_ready_before_edge", 32'(wr_ready), 32'd0);
    @(posedge clk); #1;
    check("rel_wr_ready_after_edge", 32'(wr_ready), 32'd1);

    // Miss then hit on word 5
    do_read(32'd10, 3);
    check("miss_ram_addr", 32'(ram_addr), 32'd5);
    do_read(32'd11, 3);
    check("hit_ram_addr", 32'(ram_addr), 32'd5);

    // Write to the cached word, then hit on the updated value
    do_write(17'd5, 16'h07E0);
    wait_drain();
    do_read(32'd10, 3);

    // FIFO fills while back-to-back misses keep the RAM busy
    fork
      begin
        for (int i = 0; i < 4; i++) do_read((i % 2 == 0) ? 32'd200 : 32'd400, 2);
      end
      begin
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) do_write(17'(300 + i), 16'(16'hA000 + i));
        check("fifo_full_wr_ready", 32'(wr_ready), 32'd0);
        do_write(17'd304, 16'hA004);
      end
    join
    wait_drain();
    for (int i = 0; i < 5; i++) do_read(32'(2 * (300 + i)), 3);

    // Randomized write bursts followed by reads
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) begin
        do_write(17'($urandom_range(0, 31)), 16'($urandom));
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      wait_drain();
      for (int i = 0; i < 12; i++) do_read(32'($urandom_range(0, 63)), 3 + int'($urandom_range(0, 2)));
    end

    // Out-of-range read
    check("pre_oob_err", 32'(oob_err), 32'd0);
    do_read(32'd2000, 3);
    do_read(32'(2 * DEPTH), 3);
    check("oob_rd_err", 32'(oob_err), 32'd1);
    check("oob_rd_ram_addr", 32'(ram_addr), 32'd1000);

    // Request during RD_ADDR is dropped and flagged
    check("pre_req_err", 32'(req_err), 32'd0);
    issue_read(32'd1000);
    mem_req  = 1'b1;
    mem_addr = 32'd1002;
    @(posedge clk); #1;
    mem_req = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("req_err_set", 32'(req_err), 32'd1);

    // Reset in RD_DATA aborts the read and invalidates the cache
    do_read(32'd802, 3);
    mem_req  = 1'b1;
    mem_addr = 32'd800;
    @(posedge clk); #1;
    mem_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    mc_valid = 1'b0;
    #1;
    check("abort_mem_ready", 32'(mem_ready), 32'd0);
    repeat (2) @(negedge clk);
    check("abort_wr_ready", 32'(wr_ready), 32'd0);
    check("abort_oob_err", 32'(oob_err), 32'd0);
    check("abort_req_err", 32'(req_err), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    do_read(32'd802, 3);
    do_read(32'd800, 3);

    // Out-of-range write is discarded but flagged
    do_write(17'(DEPTH), 16'hDEAD);
    do_write(17'd77, 16'h1234);
    wait_drain();
    check("oob_wr_err", 32'(oob_err), 32'd1);
    do_read(32'd154, 3);

    repeat (5) begin @(posedge clk); #1; end
    check("rd_queue_empty", 32'(rq.size()), 32'd0);
    check("wr_queue_empty", 32'(wq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
